// File: rtl/ddr4_resp.sv
// rtl/ddr4_resp.sv - DDR4 x4 device responder: command decode, bank state, CL/CWL data pipelines
module ddr4_resp #(
   parameter int CL  = 11,
   parameter int CWL = 9,
   parameter int AW  = 8
) (
   input  logic        clkin,
   input  logic        drst_n,
   input  logic        cke,
   input  logic        dcs_n,
   input  logic        dact_n,
   input  logic [16:0] da,
   input  logic [1:0]  dbg,
   input  logic [1:0]  dba,
   inout  wire  [3:0]  ddq,
   output wire         ddqs_t,
   output wire         ddqs_c,
   output logic [15:0] bank_open,
   output logic        err,
   output logic [15:0] ref_cnt
);
   localparam logic [2:0] OP_MRS = 3'b000;
   localparam logic [2:0] OP_REF = 3'b001;
   localparam logic [2:0] OP_PRE = 3'b010;
   localparam logic [2:0] OP_WR  = 3'b100;
   localparam logic [2:0] OP_RD  = 3'b101;

   logic           cmd_v;
   logic [3:0]     bank;
   logic           is_act, is_mrs, is_ref, is_pre, is_wr, is_rd;
   logic           wr_push, rd_push;
   logic [15:0]    full_addr;
   logic [AW-1:0]  acc_addr;
   logic [1:0]     row_lo [16];
   logic [CWL-1:0] wr_v;
   logic [AW-1:0]  wr_a [CWL];
   logic [CL-1:0]  rd_v;
   logic [AW-1:0]  rd_a [CL];
   logic [3:0]     mem [2**AW];
   logic           out_en;
   logic [3:0]     out_data;
   logic           unused_bits;

   assign cmd_v  = cke & ~dcs_n;
   assign bank   = {dbg, dba};
   assign is_act = cmd_v & ~dact_n;
   assign is_mrs = cmd_v & dact_n & (da[16:14] == OP_MRS);
   assign is_ref = cmd_v & dact_n & (da[16:14] == OP_REF);
   assign is_pre = cmd_v & dact_n & (da[16:14] == OP_PRE);
   assign is_wr  = cmd_v & dact_n & (da[16:14] == OP_WR);
   assign is_rd  = cmd_v & dact_n & (da[16:14] == OP_RD);

   // Only the two low row bits reach the storage address, so only they are kept.
   assign full_addr = {dbg, dba, row_lo[bank], da[9:0]};
   assign acc_addr  = full_addr[AW-1:0];
   assign wr_push   = is_wr & bank_open[bank];
   assign rd_push   = is_rd & bank_open[bank];

   assign unused_bits = ^{da[13:11], full_addr};

   always_ff @(posedge clkin or negedge drst_n) begin
      if (!drst_n) begin
         bank_open <= '0;
         err       <= 1'b0;
         ref_cnt   <= '0;
         wr_v      <= '0;
         rd_v      <= '0;
         out_en    <= 1'b0;
      end else begin
         wr_v   <= {wr_v[CWL-2:0], wr_push};
         rd_v   <= {rd_v[CL-2:0], rd_push};
         out_en <= rd_v[CL-1];
         // A write sampling edge that lands while a read beat is on the bus.
         if (out_en && wr_v[CWL-1])
            err <= 1'b1;
         if (is_act) begin
            if (bank_open[bank])
               err <= 1'b1;
            else
               bank_open[bank] <= 1'b1;
         end
         if (is_pre) begin
            if (da[10])
               bank_open <= '0;
            else
               bank_open[bank] <= 1'b0;
         end
         if (is_ref)
            ref_cnt <= ref_cnt + 16'd1;
         if ((is_ref || is_mrs) && (|bank_open))
            err <= 1'b1;
         if ((is_rd || is_wr) && !bank_open[bank])
            err <= 1'b1;
      end
   end

   // Storage and address pipelines carry no reset; the valid bits above gate them.
   always_ff @(posedge clkin) begin
      if (is_act && !bank_open[bank])
         row_lo[bank] <= da[1:0];
      wr_a[0] <= acc_addr;
      for (int i = 1; i < CWL; i++)
         wr_a[i] <= wr_a[i-1];
      rd_a[0] <= acc_addr;
      for (int i = 1; i < CL; i++)
         rd_a[i] <= rd_a[i-1];
      if (wr_v[CWL-1])
         mem[wr_a[CWL-1]] <= ddq;
      out_data <= (wr_v[CWL-1] && (wr_a[CWL-1] == rd_a[CL-1])) ? ddq : mem[rd_a[CL-1]];
   end

   assign ddq    = out_en ? out_data : 4'bzzzz;
   assign ddqs_t = out_en ? 1'b1 : 1'bz;
   assign ddqs_c = out_en ? 1'b0 : 1'bz;

endmodule
